frame_update_sequencer: RTL and testbench
=========================================

FRAME_UPDATE_SEQUENCER -- requirements
Module: frame_update_sequencer

Interface
REQ-001 Parameter NUM_ENEMIES, default 3: number of enemy slots checked per frame; legal range 1..8.
REQ-002 Parameter ENEMY_STEP_DIV, default 4: enemies step once every ENEMY_STEP_DIV frames; legal range 1..255.
REQ-003 Parameter HIT_RADIUS, default 4: box half-width for a projectile/enemy hit, in pixels.
REQ-004 Parameter BOTTOM_Y, default 8'd112: an enemy with y >= BOTTOM_Y has reached the player row.
REQ-005 clk  in  1  system clock, 50 MHz.
REQ-006 rst  in  1  reset; one clock, asynchronous, active-low.
REQ-007 vsync  in  1  VGA vertical sync, active-low pulse, synchronous to clk.
REQ-008 game_active  in  1  high while the top-level FSM is in UPDATE.
REQ-009 proj_exists  in  1  projectile is live.
REQ-010 proj_x, proj_y  in  8 each  projectile coordinates, unsigned.
REQ-011 enemy_x_flat, enemy_y_flat  in  8*NUM_ENEMIES each  enemy i at bits [8i+7:8i].
REQ-012 proj_step  out  1  one-cycle strobe: advance the projectile.
REQ-013 enemy_step  out  1  one-cycle strobe: advance all enemies.
REQ-014 enemy_respawn  out  NUM_ENEMIES  one-cycle per-enemy respawn strobe.
REQ-015 proj_kill, score_inc, health_dec  out  1 each  one-cycle strobes.
REQ-016 busy  out  1  sequence in progress; frame_done  out  1  one-cycle end-of-sequence strobe.

Function
REQ-017 States SHALL be IDLE, PROJ, ENEMY, CHECK, DONE; vsync SHALL be registered once (vsync_d), with frame_tick = vsync_d & ~vsync.
REQ-018 IDLE->PROJ on frame_tick while game_active; otherwise the FSM remains in IDLE.
REQ-019 PROJ asserts proj_step for exactly 1 cycle, then goes to ENEMY.
REQ-020 ENEMY asserts enemy_step for 1 cycle only when frame_cnt == ENEMY_STEP_DIV-1, then wraps frame_cnt to 0; otherwise frame_cnt increments. In both cases the next state is CHECK.
REQ-021 CHECK evaluates one enemy index per cycle, idx 0..NUM_ENEMIES-1, and then goes to DONE.
REQ-022 Hit = proj_exists & |proj_x-ex| <= HIT_RADIUS & |proj_y-ey| <= HIT_RADIUS; absolute difference computed as max-min in 8 bits, with no wrap.
REQ-023 On a hit for idx: pulse enemy_respawn[idx], proj_kill, score_inc in that cycle; at most one hit per frame (lowest idx wins); later indices are not hit-tested that frame.
REQ-024 For a non-hit idx with ey >= BOTTOM_Y: pulse enemy_respawn[idx] (and health_dec per REQ-033); hit takes priority over bottom-out for the same idx.
REQ-025 DONE pulses frame_done for 1 cycle, then goes to IDLE; busy is high in PROJ, ENEMY, CHECK, DONE.
REQ-026 Latency: frame_tick in cycle t -> proj_step t+1, enemy_step t+2, CHECK t+3..t+2+NUM_ENEMIES, frame_done t+3+NUM_ENEMIES.
REQ-027 A frame_tick while busy SHALL be ignored, with no queuing.
REQ-028 game_active low in any non-IDLE state SHALL force IDLE on the next edge, with no further strobes; frame_cnt SHALL clear to 0 whenever game_active is low.
REQ-029 Inputs are sampled in the CHECK cycle that uses them; strobes are registered outputs.

Reset
REQ-030 rst low: state IDLE, frame_cnt 0, vsync_d 1, CHECK index 0, hit-taken flag 0, all outputs 0.
REQ-031 rst asserted mid-sequence aborts immediately; the first frame_tick after release starts a full sequence.

Configuration
REQ-032 Macro FUS_BOTTOM_DAMAGE_EN selects the bottom-out damage behaviour.
REQ-033 Defined: bottom-out pulses health_dec together with enemy_respawn[idx]. Undefined: bottom-out pulses enemy_respawn only, and health_dec is tied to 0.

Structure
REQ-034 Shared package game_pkg holds COORD_W=8, the sequencer state encoding, and the NUM_ENEMIES default.
REQ-035 Combinational sub-module hit_detect (box compare per REQ-022) is instantiated once and muxed by the CHECK index.

Verification
REQ-036 game_active=1, vsync falls at t, no projectile -> proj_step at t+1; frame_done at t+6 (NUM_ENEMIES=3); no respawn.
REQ-037 ENEMY_STEP_DIV=4, 8 frames -> enemy_step asserted on frames 4 and 8 only.
REQ-038 proj=(50,60), enemy1=(53,57), enemy2=(50,60) -> only enemy_respawn[1], proj_kill, score_inc, each for 1 cycle.
REQ-039 enemy0 y=112, no projectile -> enemy_respawn[0]; health_dec=1 with FUS_BOTTOM_DAMAGE_EN defined, 0 without it.
REQ-040 game_active dropped at t+2 -> no CHECK strobes and no frame_done; busy=0 at t+3.
REQ-041 Second vsync fall at t+3 while busy -> ignored; exactly one frame_done.

Source files
------------

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game datapath blocks.
//   COORD_W             : width of every screen coordinate (unsigned pixels)
//   IDX_W               : width of an enemy slot index (up to 8 slots)
//   NUM_ENEMIES_DEFAULT : default number of enemy slots
//   seq_state_t         : frame update sequencer state encoding
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int COORD_W             = 8;
    localparam int IDX_W               = 3;
    localparam int NUM_ENEMIES_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PROJ  = 3'd1,
        ENEMY = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/hit_detect.sv
// -----------------------------------------------------------------------------
// hit_detect
// Combinational box compare between the projectile and one enemy.
//   proj_exists      in  projectile is live
//   proj_x, proj_y   in  projectile coordinates
//   enemy_x, enemy_y in  enemy coordinates
//   hit              out projectile inside the +/-HIT_RADIUS box of the enemy
// -----------------------------------------------------------------------------
module hit_detect
    import game_pkg::*;
#(
    parameter int HIT_RADIUS = 4
) (
    input  logic               proj_exists,
    input  logic [COORD_W-1:0] proj_x,
    input  logic [COORD_W-1:0] proj_y,
    input  logic [COORD_W-1:0] enemy_x,
    input  logic [COORD_W-1:0] enemy_y,
    output logic               hit
);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;

    // Distances are max-min so they never wrap around the screen edge.
    always_comb begin
        dx  = (proj_x >= enemy_x) ? (proj_x - enemy_x) : (enemy_x - proj_x);
        dy  = (proj_y >= enemy_y) ? (proj_y - enemy_y) : (enemy_y - proj_y);
        hit = proj_exists && (int'(dx) <= HIT_RADIUS) && (int'(dy) <= HIT_RADIUS);
    end

endmodule

// File: rtl/frame_update_sequencer.sv
// -----------------------------------------------------------------------------
// frame_update_sequencer
// Once per video frame (falling vsync) steps the projectile, steps the enemies
// every ENEMY_STEP_DIV frames, then checks each enemy slot in turn for a
// projectile hit or a bottom-out, emitting one-cycle strobes.
//
// Ports
//   clk, rst (async, active-low)
//   vsync                      in  VGA vertical sync (active-low pulse)
//   game_active                in  game is in its UPDATE phase
//   proj_exists, proj_x/_y     in  projectile state
//   enemy_x_flat/enemy_y_flat  in  enemy i at bits [8i+7:8i]
//   proj_step, enemy_step      out advance strobes
//   enemy_respawn[i]           out per-enemy respawn strobe
//   proj_kill, score_inc       out hit strobes
//   health_dec                 out bottom-out damage strobe
//   busy, frame_done           out sequence status
//
// Configuration macro FUS_BOTTOM_DAMAGE_EN: when defined a bottom-out also
// pulses health_dec; otherwise health_dec stays 0.
//
// All strobes are flops loaded on the edge that enters the cycle they belong
// to, so each CHECK slot's result is computed from the inputs present on the
// edge that opens that slot.
// -----------------------------------------------------------------------------
module frame_update_sequencer
    import game_pkg::*;
#(
    parameter int                 NUM_ENEMIES    = NUM_ENEMIES_DEFAULT,
    parameter int                 ENEMY_STEP_DIV = 4,
    parameter int                 HIT_RADIUS     = 4,
    parameter logic [COORD_W-1:0] BOTTOM_Y       = 8'd112
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           vsync,
    input  logic                           game_active,
    input  logic                           proj_exists,
    input  logic [COORD_W-1:0]             proj_x,
    input  logic [COORD_W-1:0]             proj_y,
    input  logic [COORD_W*NUM_ENEMIES-1:0] enemy_x_flat,
    input  logic [COORD_W*NUM_ENEMIES-1:0] enemy_y_flat,
    output logic                           proj_step,
    output logic                           enemy_step,
    output logic [NUM_ENEMIES-1:0]         enemy_respawn,
    output logic                           proj_kill,
    output logic                           score_inc,
    output logic                           health_dec,
    output logic                           busy,
    output logic                           frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENEMIES - 1);
    localparam logic [7:0]       LAST_CNT = 8'(ENEMY_STEP_DIV - 1);

    seq_state_t             state;
    seq_state_t             state_next;
    logic [IDX_W-1:0]       check_idx;
    logic [IDX_W-1:0]       idx_next;
    logic                   vsync_d;
    logic                   frame_tick;
    logic [7:0]             frame_cnt;
    logic [7:0]             frame_cnt_next;
    logic                   hit_taken;
    logic                   hit_taken_next;
    logic [63:0]            ex_all;
    logic [63:0]            ey_all;
    logic [COORD_W-1:0]     sel_x;
    logic [COORD_W-1:0]     sel_y;
    logic                   sel_hit;
    logic                   slot_hit;
    logic                   slot_bottom;
    logic                   enemy_step_next;
    logic [NUM_ENEMIES-1:0] respawn_next;
    logic                   kill_next;
    logic                   health_next;

    assign frame_tick = vsync_d & ~vsync;

    // Padding to 64 bits keeps the indexed select in range for any idx value.
    assign ex_all = 64'(enemy_x_flat);
    assign ey_all = 64'(enemy_y_flat);
    assign sel_x  = ex_all[{idx_next, 3'b000} +: COORD_W];
    assign sel_y  = ey_all[{idx_next, 3'b000} +: COORD_W];

    hit_detect #(
        .HIT_RADIUS (HIT_RADIUS)
    ) u_hit_detect (
        .proj_exists (proj_exists),
        .proj_x      (proj_x),
        .proj_y      (proj_y),
        .enemy_x     (sel_x),
        .enemy_y     (sel_y),
        .hit         (sel_hit)
    );

    // Once a hit has been taken this frame, later slots are not hit-tested,
    // but they can still bottom out.
    assign slot_hit    = sel_hit & ~hit_taken;
    assign slot_bottom = ~slot_hit & (sel_y >= BOTTOM_Y);

    // Next-state and slot index; dropping game_active aborts to IDLE.
    always_comb begin
        state_next = state;
        idx_next   = check_idx;
        case (state)
            IDLE: begin
                idx_next = '0;
                if (frame_tick) state_next = PROJ;
            end
            PROJ:  state_next = ENEMY;
            ENEMY: begin
                state_next = CHECK;
                idx_next   = '0;
            end
            CHECK: begin
                if (check_idx == LAST_IDX) state_next = DONE;
                else                       idx_next   = check_idx + 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
        if (!game_active) begin
            state_next = IDLE;
            idx_next   = '0;
        end
    end

    // Strobe values for the cycle being entered, plus frame divider and hit flag.
    always_comb begin
        enemy_step_next = 1'b0;
        frame_cnt_next  = frame_cnt;
        hit_taken_next  = hit_taken;
        respawn_next    = '0;
        kill_next       = 1'b0;
        health_next     = 1'b0;
        if (!game_active) begin
            frame_cnt_next = '0;
        end else if (state_next == ENEMY) begin
            hit_taken_next = 1'b0;
            if (frame_cnt == LAST_CNT) begin
                enemy_step_next = 1'b1;
                frame_cnt_next  = '0;
            end else begin
                frame_cnt_next = frame_cnt + 8'd1;
            end
        end
        if (state_next == CHECK) begin
            if (slot_hit | slot_bottom) respawn_next = NUM_ENEMIES'(1) << idx_next;
            kill_next      = slot_hit;
            hit_taken_next = hit_taken | slot_hit;
`ifdef FUS_BOTTOM_DAMAGE_EN
            health_next    = slot_bottom;
`else
            health_next    = 1'b0;
`endif
        end
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            check_idx     <= '0;
            vsync_d       <= 1'b1;
            frame_cnt     <= '0;
            hit_taken     <= 1'b0;
            proj_step     <= 1'b0;
            enemy_step    <= 1'b0;
            enemy_respawn <= '0;
            proj_kill     <= 1'b0;
            score_inc     <= 1'b0;
            health_dec    <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_next;
            check_idx     <= idx_next;
            vsync_d       <= vsync;
            frame_cnt     <= frame_cnt_next;
            hit_taken     <= hit_taken_next;
            proj_step     <= (state_next == PROJ);
            enemy_step    <= enemy_step_next;
            enemy_respawn <= respawn_next;
            proj_kill     <= kill_next;
            score_inc     <= kill_next;
            health_dec    <= health_next;
            busy          <= (state_next != IDLE);
            frame_done    <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_update_sequencer
// Directed, table-driven bench for frame_update_sequencer with default
// parameters (3 enemies, step divider 4, radius 4, bottom row 112).
// Honours FUS_BOTTOM_DAMAGE_EN for the expected health_dec value.
// -----------------------------------------------------------------------------
module tb_frame_update_sequencer;

    localparam int N    = 3;
    localparam int NREL = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        game_active;
    logic        proj_exists;
    logic [7:0]  proj_x;
    logic [7:0]  proj_y;
    logic [23:0] enemy_x_flat;
    logic [23:0] enemy_y_flat;
    logic        proj_step;
    logic        enemy_step;
    logic [2:0]  enemy_respawn;
    logic        proj_kill;
    logic        score_inc;
    logic        health_dec;
    logic        busy;
    logic        frame_done;

    int checkCount = 0;
    int errorCount = 0;
    int modelCnt   = 0;

    typedef struct packed {
        logic        pe;
        logic [7:0]  px;
        logic [7:0]  py;
        logic [23:0] ex;
        logic [23:0] ey;
        logic [2:0]  resp;
        logic [2:0]  kill;
        logic [2:0]  hd;
    } vec_t;

    vec_t vecs [10];

    // Per-frame logs, indexed by cycle relative to the frame tick.
    logic [NREL-1:0] psVec, esVec, fdVec, bzVec, pkVec, siVec, hdVec;
    logic [2:0]      rsLog [NREL];

    frame_update_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .vsync         (vsync),
        .game_active   (game_active),
        .proj_exists   (proj_exists),
        .proj_x        (proj_x),
        .proj_y        (proj_y),
        .enemy_x_flat  (enemy_x_flat),
        .enemy_y_flat  (enemy_y_flat),
        .proj_step     (proj_step),
        .enemy_step    (enemy_step),
        .enemy_respawn (enemy_respawn),
        .proj_kill     (proj_kill),
        .score_inc     (score_inc),
        .health_dec    (health_dec),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic pe, input logic [7:0] px, input logic [7:0] py,
                                   input logic [7:0] e0x, input logic [7:0] e0y,
                                   input logic [7:0] e1x, input logic [7:0] e1y,
                                   input logic [7:0] e2x, input logic [7:0] e2y,
                                   input logic [2:0] resp, input logic [2:0] kill,
                                   input logic [2:0] hd);
        vec_t v;
        v.pe = pe; v.px = px; v.py = py;
        v.ex = {e2x, e1x, e0x};
        v.ey = {e2y, e1y, e0y};
        v.resp = resp; v.kill = kill; v.hd = hd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        proj_exists  = v.pe;
        proj_x       = v.px;
        proj_y       = v.py;
        enemy_x_flat = v.ex;
        enemy_y_flat = v.ey;
    endtask

    // Falls vsync at relative cycle 0 and logs NREL cycles of outputs.
    task automatic runFrame(input int dropAt, input int retickAt);
        @(posedge clk); #1;
        for (int r = 0; r < NREL; r++) begin
            if (r == 0) vsync = 1'b0;
            if (r == 2) vsync = 1'b1;
            if (r == dropAt) game_active = 1'b0;
            if (r == retickAt) vsync = 1'b0;
            if (r == retickAt + 1) vsync = 1'b1;
            @(negedge clk);
            psVec[r] = proj_step;  esVec[r] = enemy_step; fdVec[r] = frame_done;
            bzVec[r] = busy;       pkVec[r] = proj_kill;  siVec[r] = score_inc;
            hdVec[r] = health_dec; rsLog[r] = enemy_respawn;
            @(posedge clk); #1;
        end
    endtask

    task automatic checkFrameTiming(input string tag);
        checkOutput({tag, " proj_step"},  32'(psVec), 32'h002);
        checkOutput({tag, " frame_done"}, 32'(fdVec), 32'h040);
        checkOutput({tag, " busy"},       32'(bzVec), 32'h07e);
    endtask

    task automatic checkEnemyStep(input string tag);
        logic [NREL-1:0] expEs;
        expEs = (modelCnt == 3) ? 12'h004 : 12'h000;
        modelCnt = (modelCnt == 3) ? 0 : modelCnt + 1;
        checkOutput({tag, " enemy_step"}, 32'(esVec), 32'(expEs));
    endtask

    task automatic checkStrobes(input string tag, input vec_t v);
        logic [2:0] obsResp, obsKill, obsScore, obsHd, expHd;
        int stray;
        stray = 0;
        obsResp = '0; obsKill = '0; obsScore = '0; obsHd = '0;
        for (int k = 0; k < N; k++) begin
            obsResp[k]  = rsLog[3 + k][k];
            obsKill[k]  = pkVec[3 + k];
            obsScore[k] = siVec[3 + k];
            obsHd[k]    = hdVec[3 + k];
        end
        for (int r = 0; r < NREL; r++) begin
            for (int b = 0; b < N; b++)
                if (rsLog[r][b] && r != 3 + b) stray++;
            if (r < 3 || r > 5) stray += int'(pkVec[r]) + int'(siVec[r]) + int'(hdVec[r]);
        end
`ifdef FUS_BOTTOM_DAMAGE_EN
        expHd = v.hd;
`else
        expHd = 3'b000;
`endif
        checkOutput({tag, " respawn"},    32'(obsResp),  32'(v.resp));
        checkOutput({tag, " proj_kill"},  32'(obsKill),  32'(v.kill));
        checkOutput({tag, " score_inc"},  32'(obsScore), 32'(v.kill));
        checkOutput({tag, " health_dec"}, 32'(obsHd),    32'(expHd));
        checkOutput({tag, " stray"},      32'(stray),    32'd0);
    endtask

    task automatic resetDut();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        modelCnt = 0;
    endtask

    initial begin
        int anyStrobe;
        rst = 1'b0; vsync = 1'b1; game_active = 1'b1; proj_exists = 1'b0;
        proj_x = '0; proj_y = '0; enemy_x_flat = '0; enemy_y_flat = '0;

        // Reset state
        #12;
        checkOutput("rst proj_step",  32'(proj_step),     32'd0);
        checkOutput("rst enemy_step", 32'(enemy_step),    32'd0);
        checkOutput("rst respawn",    32'(enemy_respawn), 32'd0);
        checkOutput("rst proj_kill",  32'(proj_kill),     32'd0);
        checkOutput("rst score_inc",  32'(score_inc),     32'd0);
        checkOutput("rst health_dec", 32'(health_dec),    32'd0);
        checkOutput("rst busy",       32'(busy),          32'd0);
        checkOutput("rst frame_done", 32'(frame_done),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        modelCnt = 0;

        //                 pe  px   py   e0x  e0y  e1x  e1y  e2x  e2y  resp    kill    hd
        vecs[0] = mkVec(0,   0,   0,  10,  10,  20,  20,  30,  30, 3'b000, 3'b000, 3'b000);
        vecs[1] = mkVec(1,  50,  60, 100,  10,  53,  57,  50,  60, 3'b010, 3'b010, 3'b000);
        vecs[2] = mkVec(0,   0,   0,  40, 112,  20,  20,  30,  30, 3'b001, 3'b000, 3'b001);
        vecs[3] = mkVec(1, 100, 100, 104,  96,  10,  10,  20,  20, 3'b001, 3'b001, 3'b000);
        vecs[4] = mkVec(1, 100, 100, 105, 100,  95, 100, 100,  95, 3'b000, 3'b000, 3'b000);
        vecs[5] = mkVec(0,  50,  50,  50,  50,  10,  10,  20,  20, 3'b000, 3'b000, 3'b000);
        vecs[6] = mkVec(1,  60, 115,  62, 113,  10, 120,  20, 111, 3'b011, 3'b001, 3'b010);
        vecs[7] = mkVec(1,   2,   2, 254,   2,   0,   0,   2,   2, 3'b010, 3'b010, 3'b000);
        vecs[8] = mkVec(0,   0,   0,  10, 111,  20, 255,  30, 112, 3'b110, 3'b000, 3'b110);
        vecs[9] = mkVec(1, 200, 200, 198, 203, 200, 200,  10,  10, 3'b011, 3'b001, 3'b010);

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
            runFrame(-1, -5);
            checkFrameTiming(tag);
            checkEnemyStep(tag);
            checkStrobes(tag, vecs[i]);
        end

        // Enemy step divider over 8 frames from a fresh reset
        resetDut();
        applyStimulus(vecs[0]);
        for (int f = 1; f <= 8; f++) begin
            runFrame(-1, -5);
            checkOutput($sformatf("div frame%0d enemy_step", f), 32'(esVec),
                        (f == 4 || f == 8) ? 32'h004 : 32'h000);
        end
        modelCnt = 0;

        // game_active dropped during ENEMY aborts the frame
        applyStimulus(vecs[2]);
        runFrame(2, -5);
        anyStrobe = 0;
        for (int r = 0; r < NREL; r++)
            anyStrobe += int'(rsLog[r] != 3'b000) + int'(pkVec[r]) + int'(siVec[r]) + int'(hdVec[r]);
        checkOutput("drop proj_step",  32'(psVec), 32'h002);
        checkOutput("drop busy",       32'(bzVec), 32'h006);
        checkOutput("drop frame_done", 32'(fdVec), 32'h000);
        checkOutput("drop strobes",    32'(anyStrobe), 32'd0);
        game_active = 1'b1;
        modelCnt = 0;

        // Second vsync fall while busy is ignored
        applyStimulus(vecs[1]);
        runFrame(-1, 3);
        checkFrameTiming("retick");
        checkEnemyStep("retick");
        checkStrobes("retick", vecs[1]);

        // Reset asserted mid-sequence, then a full frame afterwards
        applyStimulus(vecs[2]);
        @(posedge clk); #1 vsync = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst pre respawn", 32'(enemy_respawn), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst busy",       32'(busy),          32'd0);
        checkOutput("midrst respawn",    32'(enemy_respawn), 32'd0);
        checkOutput("midrst frame_done", 32'(frame_done),    32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        modelCnt = 0;
        runFrame(-1, -5);
        checkFrameTiming("postrst");
        checkEnemyStep("postrst");
        checkStrobes("postrst", vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
